step_sequencer: RTL and testbench
=================================

# step_sequencer

Converts the divided clock from the clock divider into single-cycle tick enables in the `i_clk` domain. It uses those ticks to run a programmable step counter (one-shot or looping) with start, pause and abort control. It sits directly downstream of the divider and drives game and LED pattern logic, which must never clock on the slow clock itself.

## Interface
- `STEP_W`, default 4: width of the step index and of the step count.

Ports:
- `i_clk`  in  1  system clock; every register is clocked on its rising edge.
- `i_rst_n`  in  1  synchronous, active-low reset.
- `i_slow_clk`  in  1  divided clock from the clock divider, registered in the `i_clk` domain; used as data only.
- `i_start`  in  1  start request, sampled every cycle.
- `i_pause`  in  1  level; holds the sequence while high.
- `i_abort`  in  1  forces IDLE.
- `i_loop`  in  1  loop mode, latched at start.
- `i_num_steps`  in  `STEP_W`  number of steps N, latched at start; valid values are 1..2^STEP_W-1.
- `o_tick`  out  1  one-cycle pulse per rising edge of `i_slow_clk`.
- `o_step`  out  `STEP_W`  current step index.
- `o_step_valid`  out  1  high while in RUN or PAUSE.
- `o_step_pulse`  out  1  one-cycle pulse each time a step begins.
- `o_done`  out  1  one-cycle pulse when a one-shot sequence completes.
- `o_busy`  out  1  high while in RUN or PAUSE.

## Operation
**Edge detect**
- `slow_prev` holds the last sample of `i_slow_clk`.
- `tick = i_slow_clk & ~slow_prev`.
- `slow_prev` resets to 1, so no tick is produced until `i_slow_clk` has been seen low and then high.

**State machine:** states are IDLE, RUN and PAUSE. Priority within a cycle is abort > start > pause > tick.
- IDLE:
  - `i_start` with `i_num_steps` != 0: go to RUN, latch N and loop, set `o_step`=0, pulse `o_step_pulse`.
  - `i_start` with `i_num_steps` = 0: ignore; stay in IDLE with no pulses.
- RUN:
  - `i_pause`=1: go to PAUSE; a tick in the same cycle is dropped.
  - Tick with `o_step` < N-1: `o_step`+1, pulse `o_step_pulse`.
  - Tick with `o_step` = N-1 and loop=1: `o_step`=0, pulse `o_step_pulse`; no `o_done`.
  - Tick with `o_step` = N-1 and loop=0: go to IDLE, `o_step`=0, pulse `o_done`.
- PAUSE:
  - Ticks are not counted; `o_tick` still pulses.
  - `i_pause`=0: return to RUN with `o_step` unchanged and no `o_step_pulse`.
- `i_abort`, any state: go to IDLE, `o_step`=0, no `o_done`, no `o_step_pulse`.
- `i_start` while busy is ignored. Latched N and loop do not change mid-sequence.
- A start in the same cycle as a tick: the tick is not counted, and step 0 lasts until the next tick.
- N=1 one-shot: the first counted tick completes the sequence.
- N=1 loop: every counted tick pulses `o_step_pulse` with `o_step` held at 0.
- `o_step` is always < N while `o_step_valid`=1 and never wraps past N-1.

## Timing
- All outputs are registered and update on the `i_clk` edge that samples the triggering condition.
- Reset values: `o_tick`=0, `o_step`=0, `o_step_valid`=0, `o_step_pulse`=0, `o_done`=0, `o_busy`=0. State resets to IDLE, latched N and loop to 0, `slow_prev` to 1.
- Reset applied mid-sequence returns the block to IDLE at that edge, with no `o_done` pulse.
- `o_tick` is high for exactly one cycle, at the edge where `i_slow_clk` is sampled 1 after a previous sample of 0. With divider ratio R, ticks are spaced 2R cycles apart.
- Tick-driven changes to `o_step`, `o_step_pulse` and `o_done` occur at the same edge as the `o_tick` rise.
- Start latency is one edge: `o_busy`, `o_step_valid` and `o_step_pulse` all rise at the edge that samples `i_start`.
- `o_done` coincides with `o_busy` falling.
- Abort takes effect at the edge that samples it.

## Test plan
- **Tick generation:** reset, then drive `i_slow_clk` with R=2 (period 4 cycles) for 20 cycles → 5 `o_tick` pulses, 4 cycles apart; if `i_slow_clk` is high coming out of reset, no tick until its first low-to-high transition.
- **One-shot run:** N=3, loop=0, start → `o_step` 0,1,2 on successive ticks with 3 `o_step_pulse`; next tick gives `o_done`=1 for one cycle, `o_busy`=0 and `o_step`=0.
- **Loop with pause:** N=2, loop=1 → sequence 0,1,0,1 with no `o_done`. Hold `i_pause` over 3 ticks → `o_step` frozen and `o_tick` still pulses. Release → resumes from the same step with no extra `o_step_pulse`.
- **Simultaneous events:**
  - start on a tick cycle → `o_step` stays 0 until the next tick;
  - start with `i_num_steps`=0 → stays IDLE;
  - start while busy → ignored;
  - abort with pause and tick at step 1 → IDLE, `o_step`=0, no `o_done`.
- **Reset mid-sequence:** N=5 at step 3, `i_rst_n`=0 for one cycle → all outputs 0 at that edge; a following start begins cleanly at step 0.

Source files
------------

// File: rtl/step_sequencer.sv
// step_sequencer: turns the divided slow clock into single-cycle tick enables
// in the i_clk domain and runs a programmable one-shot or looping step counter
// with start, pause and abort control.
module step_sequencer #(
   parameter int unsigned STEP_W = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_slow_clk,
   input  logic              i_start,
   input  logic              i_pause,
   input  logic              i_abort,
   input  logic              i_loop,
   input  logic [STEP_W-1:0] i_num_steps,
   output logic              o_tick,
   output logic [STEP_W-1:0] o_step,
   output logic              o_step_valid,
   output logic              o_step_pulse,
   output logic              o_done,
   output logic              o_busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               slow_prev_q, slow_prev_d;
   logic               tick_q, tick_d;
   logic [STEP_W-1:0]  step_q, step_d;
   logic [STEP_W-1:0]  num_q, num_d;
   logic               loop_q, loop_d;
   logic               step_pulse_q, step_pulse_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;
   logic               tick;
   logic               last_step;

   assign tick      = i_slow_clk & ~slow_prev_q;
   // Treat anything at or beyond N-1 as the last step so the index never wraps past N-1.
   assign last_step = (step_q >= (num_q - STEP_W'(1)));

   // Next-state, step counter and output pulse decode; abort > start > pause > tick.
   always_comb begin
      state_d      = state_q;
      step_d       = step_q;
      num_d        = num_q;
      loop_d       = loop_q;
      step_pulse_d = 1'b0;
      done_d       = 1'b0;
      slow_prev_d  = i_slow_clk;
      tick_d       = tick;

      if (i_abort) begin
         state_d = S_IDLE;
         step_d  = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (i_start && (i_num_steps != '0)) begin
                  state_d      = S_RUN;
                  num_d        = i_num_steps;
                  loop_d       = i_loop;
                  step_d       = '0;
                  step_pulse_d = 1'b1;
               end
            end
            S_RUN: begin
               if (i_pause) begin
                  state_d = S_PAUSE;
               end else if (tick) begin
                  if (!last_step) begin
                     step_d       = step_q + STEP_W'(1);
                     step_pulse_d = 1'b1;
                  end else if (loop_q) begin
                     step_d       = '0;
                     step_pulse_d = 1'b1;
                  end else begin
                     state_d = S_IDLE;
                     step_d  = '0;
                     done_d  = 1'b1;
                  end
               end
            end
            S_PAUSE: begin
               if (!i_pause) begin
                  state_d = S_RUN;
               end
            end
            default: begin
               state_d = S_IDLE;
               step_d  = '0;
            end
         endcase
      end

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q      <= S_IDLE;
         slow_prev_q  <= 1'b1;
         tick_q       <= 1'b0;
         step_q       <= '0;
         num_q        <= '0;
         loop_q       <= 1'b0;
         step_pulse_q <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         slow_prev_q  <= slow_prev_d;
         tick_q       <= tick_d;
         step_q       <= step_d;
         num_q        <= num_d;
         loop_q       <= loop_d;
         step_pulse_q <= step_pulse_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
      end
   end

   assign o_tick       = tick_q;
   assign o_step       = step_q;
   assign o_step_valid = busy_q;
   assign o_step_pulse = step_pulse_q;
   assign o_done       = done_q;
   assign o_busy       = busy_q;

endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: directed vectors with hand-computed expectations for step_sequencer.
module tb_step_sequencer;

   localparam int unsigned STEP_W = 4;

   logic              clk;
   logic              rst_n;
   logic              slow_clk;
   logic              start;
   logic              pause;
   logic              abort_r;
   logic              loop_r;
   logic [STEP_W-1:0] num_steps;
   logic              tick;
   logic [STEP_W-1:0] step;
   logic              step_valid;
   logic              step_pulse;
   logic              done;
   logic              busy;

   int unsigned errors;
   int unsigned checks;

   step_sequencer #(.STEP_W(STEP_W)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_slow_clk   (slow_clk),
      .i_start      (start),
      .i_pause      (pause),
      .i_abort      (abort_r),
      .i_loop       (loop_r),
      .i_num_steps  (num_steps),
      .o_tick       (tick),
      .o_step       (step),
      .o_step_valid (step_valid),
      .o_step_pulse (step_pulse),
      .o_done       (done),
      .o_busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock edge; outputs are sampled 1 time unit after it.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Low then high on the slow clock; returns right after the tick edge.
   task automatic do_tick();
      slow_clk = 1'b0;
      cyc();
      slow_clk = 1'b1;
      cyc();
   endtask

   task automatic check_outs(input string tag, input logic t, input logic [STEP_W-1:0] s,
                             input logic p, input logic d, input logic b);
      check({tag, ".tick"},  32'(t), 32'(tick ));
      check({tag, ".step"},  32'(step), 32'(s));
      check({tag, ".pulse"}, 32'(step_pulse), 32'(p));
      check({tag, ".done"},  32'(done), 32'(d));
      check({tag, ".busy"},  32'(busy), 32'(b));
      check({tag, ".valid"}, 32'(step_valid), 32'(b));
   endtask

   initial begin
      int unsigned nticks;
      errors    = 0;
      checks    = 0;
      rst_n     = 1'b0;
      slow_clk  = 1'b1;
      start     = 1'b0;
      pause     = 1'b0;
      abort_r   = 1'b0;
      loop_r    = 1'b0;
      num_steps = '0;

      // Reset state
      cyc();
      cyc();
      check_outs("reset", 1'b1 & tick, 4'd0, 1'b0, 1'b0, 1'b0);
      check("reset_tick", 32'(tick), 32'd0);

      // Slow clock high out of reset: no tick
      rst_n = 1'b1;
      cyc();
      check("no_tick_hi0", 32'(tick), 32'd0);
      cyc();
      check("no_tick_hi1", 32'(tick), 32'd0);

      // Tick generation, R=2: pattern 0,0,1,1 for 20 cycles -> ticks at cycles 2,6,10,14,18
      nticks = 0;
      for (int i = 0; i < 20; i++) begin
         slow_clk = ((i % 4) >= 2);
         cyc();
         if (tick) nticks++;
         check($sformatf("tickgen%0d", i), 32'(tick), ((i % 4) == 2) ? 32'd1 : 32'd0);
      end
      check("tick_count", nticks, 32'd5);

      // One-shot N=3
      num_steps = 4'd3;
      loop_r    = 1'b0;
      start     = 1'b1;
      cyc();
      start = 1'b0;
      check_outs("os_start", 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
      cyc();
      check_outs("os_hold", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      do_tick();
      check_outs("os_t1", 1'b1, 4'd1, 1'b1, 1'b0, 1'b1);
      cyc();
      check_outs("os_t1b", 1'b0, 4'd1, 1'b0, 1'b0, 1'b1);
      do_tick();
      check_outs("os_t2", 1'b1, 4'd2, 1'b1, 1'b0, 1'b1);
      do_tick();
      check_outs("os_done", 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
      cyc();
      check_outs("os_after", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

      // Loop N=2 with pause
      num_steps = 4'd2;
      loop_r    = 1'b1;
      start     = 1'b1;
      cyc();
      start = 1'b0;
      check_outs("lp_start", 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
      do_tick();
      check_outs("lp_t1", 1'b1, 4'd1, 1'b1, 1'b0, 1'b1);
      do_tick();
      check_outs("lp_t2", 1'b1, 4'd0, 1'b1, 1'b0, 1'b1);
      do_tick();
      check_outs("lp_t3", 1'b1, 4'd1, 1'b1, 1'b0, 1'b1);
      slow_clk = 1'b0;
      cyc();
      slow_clk = 1'b1;
      pause    = 1'b1;
      cyc();
      check_outs("lp_pause_tick", 1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         do_tick();
         check_outs($sformatf("lp_paused%0d", i), 1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
      end
      pause = 1'b0;
      cyc();
      check_outs("lp_resume", 1'b0, 4'd1, 1'b0, 1'b0, 1'b1);
      do_tick();
      check_outs("lp_t4", 1'b1, 4'd0, 1'b1, 1'b0, 1'b1);
      abort_r = 1'b1;
      cyc();
      abort_r = 1'b0;
      check_outs("lp_abort", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

      // Start on a tick cycle
      slow_clk = 1'b0;
      cyc();
      slow_clk  = 1'b1;
      num_steps = 4'd3;
      loop_r    = 1'b0;
      start     = 1'b1;
      cyc();
      start = 1'b0;
      check_outs("st_tick", 1'b1, 4'd0, 1'b1, 1'b0, 1'b1);
      cyc();
      check_outs("st_tick_hold", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      do_tick();
      check_outs("st_tick_next", 1'b1, 4'd1, 1'b1, 1'b0, 1'b1);
      abort_r = 1'b1;
      cyc();
      abort_r = 1'b0;
      check_outs("st_abort", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

      // Start with N=0 ignored
      num_steps = 4'd0;
      start     = 1'b1;
      cyc();
      start = 1'b0;
      check_outs("n0_start", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

      // Start while busy ignored; latched N=2, one-shot
      num_steps = 4'd2;
      loop_r    = 1'b0;
      start     = 1'b1;
      cyc();
      start = 1'b0;
      check_outs("bz_start", 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
      do_tick();
      check_outs("bz_t1", 1'b1, 4'd1, 1'b1, 1'b0, 1'b1);
      num_steps = 4'd5;
      loop_r    = 1'b1;
      start     = 1'b1;
      cyc();
      start = 1'b0;
      check_outs("bz_restart", 1'b0, 4'd1, 1'b0, 1'b0, 1'b1);
      do_tick();
      check_outs("bz_done", 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);

      // Abort together with pause and tick at step 1
      num_steps = 4'd3;
      loop_r    = 1'b0;
      start     = 1'b1;
      cyc();
      start = 1'b0;
      do_tick();
      check_outs("ab_t1", 1'b1, 4'd1, 1'b1, 1'b0, 1'b1);
      slow_clk = 1'b0;
      cyc();
      slow_clk = 1'b1;
      abort_r  = 1'b1;
      pause    = 1'b1;
      cyc();
      abort_r = 1'b0;
      pause   = 1'b0;
      check_outs("ab_all", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);

      // N=1 one-shot: first counted tick completes
      num_steps = 4'd1;
      start     = 1'b1;
      cyc();
      start = 1'b0;
      check_outs("n1_start", 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
      do_tick();
      check_outs("n1_done", 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);

      // Reset mid-sequence, N=5 at step 3
      num_steps = 4'd5;
      start     = 1'b1;
      cyc();
      start = 1'b0;
      do_tick();
      do_tick();
      do_tick();
      check_outs("rs_s3", 1'b1, 4'd3, 1'b1, 1'b0, 1'b1);
      slow_clk = 1'b0;
      cyc();
      slow_clk = 1'b1;
      rst_n    = 1'b0;
      cyc();
      rst_n = 1'b1;
      check_outs("rs_reset", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      start = 1'b1;
      cyc();
      start = 1'b0;
      check_outs("rs_restart", 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
      do_tick();
      check_outs("rs_t1", 1'b1, 4'd1, 1'b1, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
